mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle main controller for the MIPS datapath: the producer side of the 4-bit ALU operation interface and of every datapath enable. It sequences fetch, decode, execute, memory and write-back over several cycles of a single clock. It consumes the ALU `Zero` flag and the instruction-register opcode/funct fields, and drives ALU opcodes in the ALU's own encoding.

## Interface
Parameters:
- `RESET_PC_EN`, 1, when 1 `pc_en` is held low during the first cycle after reset release. The first fetch starts one cycle late.

Ports. One clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU Zero flag
- `pc_en`  out  1  PC load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`, `ir_write`, `reg_write`  out  1 each
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write data: 0 = ALUOut, 1 = MDR
- `alu_src_a`  out  1  ALU A: 0 = PC, 1 = A
- `alu_src_b`  out  2  ALU B: 0 = B, 1 = const 4, 2 = extended imm, 3 = sign-ext imm<<2
- `ext_zero`  out  1  imm extension: 1 = zero-extend
- `pc_src`  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
- `alu_op`  out  4  ALU opcode
- `illegal_op`  out  1  one-cycle pulse on an unsupported instruction

## Operation
ALU opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR, 15 no-op (ALU returns 0).

State machine:
- **FETCH**: `mem_read` = 1, `ir_write` = 1, `alu_src_a` = 0, `alu_src_b` = 1, `alu_op` = 2, `pc_src` = 0, `pc_en` = 1. Next state DECODE.
- **DECODE**: `alu_src_a` = 0, `alu_src_b` = 3, `alu_op` = 2 (branch target into ALUOut). Dispatch on opcode:
  - 0x00 with a valid funct → REXEC
  - 0x23 lw and 0x2B sw → MEMADR
  - 0x04 beq → BRANCH
  - 0x02 j → JUMP
  - immediate ops → IEXEC
  - anything else → `illegal_op` = 1, next state FETCH
- Valid R-type functs: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt.
- **MEMADR**: `alu_src_a` = 1, `alu_src_b` = 2, `alu_op` = 2. lw → MEMRD, sw → MEMWR.
- **MEMRD**: `iord` = 1, `mem_read` = 1. Next state MEMWB.
- **MEMWB**: `reg_write` = 1, `mem_to_reg` = 1, `reg_dst` = 0. Next state FETCH.
- **MEMWR**: `iord` = 1, `mem_write` = 1. Next state FETCH.
- **REXEC**: `alu_src_a` = 1, `alu_src_b` = 0, `alu_op` = funct-decoded value. Next state RWB.
- **RWB**: `reg_write` = 1, `reg_dst` = 1, `mem_to_reg` = 0. Next state FETCH.
- **BRANCH**: `alu_src_a` = 1, `alu_src_b` = 0, `alu_op` = 6, `pc_src` = 1, `pc_en` = `zero`. Next state FETCH.
- **JUMP**: `pc_src` = 2, `pc_en` = 1. Next state FETCH.
- **IEXEC** / **IWB**: immediate execute, then write-back with `reg_dst` = 0; see Configuration.

Output rules:
- All outputs not listed for a state are 0. `alu_op` defaults to 15.
- Outputs are pure decodes of the state register, except `pc_en` in BRANCH, which is combinational on `zero`.

## Timing
- Reset (`rst_n` low at a clock edge): state goes to FETCH on that edge, including mid-instruction. No write enable is asserted in the reset cycle.
- With `RESET_PC_EN` = 1: `pc_en`, `ir_write` and `mem_read` are low in the first post-reset cycle (state HOLD), then FETCH follows.
- Cycle counts including FETCH: beq and j = 3; R-type, sw and imm = 4; lw = 5.
- `illegal_op` is high for exactly the DECODE cycle and costs 2 cycles total.
- `opcode`/`funct` are sampled only in DECODE and REXEC/IEXEC. Changes at other times are ignored.

## Configuration
- `MC_IMM_OPS_EN` defined: opcodes 0x08 addi, 0x0C andi, 0x0D ori and 0x0A slti are legal.
  - IEXEC: `alu_src_a` = 1, `alu_src_b` = 2, `alu_op` = 2/0/1/7 respectively, `ext_zero` = 1 for andi/ori only.
  - IWB: `reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 0.
- `MC_IMM_OPS_EN` undefined: IEXEC and IWB do not exist, those opcodes raise `illegal_op`, and `ext_zero` is tied to 0.

## Structure
- Shared package `mc_defs`: state encoding, ALU opcode constants (including 15 = no-op), opcode and funct constants, and `alu_src_b`/`pc_src` select values. The ALU side uses the same package.
- One sub-module, `alu_op_decode`: combinational map from funct to alu_op plus a valid flag. It is reused by DECODE (legality check) and REXEC (opcode).

## Test plan
- Reset mid-lw (assert `rst_n` = 0 in MEMRD) → next cycle FETCH, `mem_read` and `reg_write` are not asserted in the reset cycle.
- R-type funct 0x22 → 4 cycles, `alu_op` = 6 in REXEC, `reg_write` = 1 with `reg_dst` = 1 in RWB.
- beq with `zero` = 1, then with `zero` = 0 → `pc_en` = 1 with `pc_src` = 1 for the first, `pc_en` = 0 for the second; both return to FETCH after 3 cycles.
- lw (0x23) → 5 cycles, `iord` = 1 in MEMRD, `mem_to_reg` = 1 with `reg_write` = 1 in MEMWB.
- Opcode 0x3F, and opcode 0x00 with funct 0x01 → `illegal_op` pulses for 1 cycle, no write enables, back in FETCH after 2 cycles.
- ori (0x0D) → with `MC_IMM_OPS_EN`: `alu_op` = 1, `ext_zero` = 1, write-back to rt. Without `MC_IMM_OPS_EN`: `illegal_op` is asserted.

Source files
------------

// File: rtl/mc_control_pkg.sv
// mc_defs: shared encodings for the multi-cycle controller and the ALU side.
package mc_defs;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, RWB,
    BRANCH, JUMP, IEXEC, IWB, HOLD
  } state_t;
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd15;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [1:0] SRCB_B   = 2'd0;
  localparam logic [1:0] SRCB_4   = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_BR  = 2'd3;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
  } ctrl_t;
  // Control word for a state; pc_en in BRANCH is added later from zero.
  function automatic ctrl_t ctrl_of(state_t s, logic [3:0] rop, logic [3:0] iop, logic iext);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_NOP;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = SRCB_4; c.alu_op = ALU_ADD; c.pc_src = PC_ALU; c.pc_en = 1'b1; end
      DECODE: begin c.alu_src_b = SRCB_BR; c.alu_op = ALU_ADD; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
      MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      REXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = rop; end
      RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_SUB; c.pc_src = PC_ALUOUT; end
      JUMP:   begin c.pc_src = PC_JUMP; c.pc_en = 1'b1; end
      IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = iop; c.ext_zero = iext; end
      IWB:    c.reg_write = 1'b1;
      default: ;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: controller <-> datapath signals; master is the controller.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_en;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       illegal_op;
  modport master(
    input  opcode, funct, zero,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, ext_zero, pc_src, alu_op, illegal_op
  );
  modport slave(
    output opcode, funct, zero,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, ext_zero, pc_src, alu_op, illegal_op
  );
endinterface

// File: rtl/mc_control_alu_op_decode.sv
// alu_op_decode: R-type funct to ALU opcode, with a legality flag.
module alu_op_decode
  import mc_defs::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       valid
);
  assign alu_op = funct == FN_ADD ? ALU_ADD :
                  funct == FN_SUB ? ALU_SUB :
                  funct == FN_AND ? ALU_AND :
                  funct == FN_OR  ? ALU_OR  :
                  funct == FN_NOR ? ALU_NOR :
                  funct == FN_SLT ? ALU_SLT : ALU_NOP;
  assign valid = alu_op != ALU_NOP;
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main controller; define MC_IMM_OPS_EN to
// enable addi/andi/ori/slti.
module mc_control
  import mc_defs::*;
#(
  parameter bit RESET_PC_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  mc_control_if.master bus
);
  state_t     state, nxt, s_d, rst_s;
  ctrl_t      ctrl;
  logic [3:0] r_op, imm_op;
  logic       r_ok, imm_ok, imm_ext, is_lw;
  alu_op_decode u_dec (.funct(bus.funct), .alu_op(r_op), .valid(r_ok));
`ifdef MC_IMM_OPS_EN
  assign imm_op = bus.opcode == OP_ADDI ? ALU_ADD :
                  bus.opcode == OP_ANDI ? ALU_AND :
                  bus.opcode == OP_ORI  ? ALU_OR  :
                  bus.opcode == OP_SLTI ? ALU_SLT : ALU_NOP;
  assign imm_ok  = imm_op != ALU_NOP;
  assign imm_ext = bus.opcode == OP_ANDI || bus.opcode == OP_ORI;
`else
  assign imm_op  = ALU_NOP;
  assign imm_ok  = 1'b0;
  assign imm_ext = 1'b0;
`endif
  assign rst_s = RESET_PC_EN ? HOLD : FETCH;
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = DECODE;
      DECODE: nxt = (bus.opcode == OP_RTYPE && r_ok) ? REXEC :
                    (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                    bus.opcode == OP_BEQ ? BRANCH :
                    bus.opcode == OP_J ? JUMP :
                    imm_ok ? IEXEC : FETCH;
      MEMADR: nxt = is_lw ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      REXEC:  nxt = RWB;
      IEXEC:  nxt = IWB;
      default: nxt = FETCH;
    endcase
    s_d = rst_n ? nxt : rst_s;
  end
  // Control word is registered for the state being entered; lw/sw is latched in DECODE.
  always_ff @(posedge clk) begin
    state <= s_d;
    ctrl  <= ctrl_of(s_d, r_op, imm_op, imm_ext);
    if (state == DECODE) is_lw <= bus.opcode == OP_LW;
  end
  // Enables are masked while rst_n is low so an aborted instruction cannot write.
  assign bus.pc_en      = rst_n & (ctrl.pc_en | (state == BRANCH & bus.zero));
  assign bus.mem_read   = rst_n & ctrl.mem_read;
  assign bus.mem_write  = rst_n & ctrl.mem_write;
  assign bus.ir_write   = rst_n & ctrl.ir_write;
  assign bus.reg_write  = rst_n & ctrl.reg_write;
  assign bus.iord       = ctrl.iord;
  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.ext_zero   = ctrl.ext_zero;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.illegal_op = state == DECODE && nxt == FETCH;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: randomized per-cycle check of mc_control against an instruction-level model.
module tb_mc_control;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mc_control_if bus();
  mc_control dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
`ifdef MC_IMM_OPS_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       illegal_op;
  } obs_t;
  function automatic obs_t observe();
    return obs_t'({bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                   bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                   bus.alu_src_b, bus.ext_zero, bus.pc_src, bus.alu_op, bus.illegal_op});
  endfunction
  function automatic obs_t idle();
    obs_t o;
    o = '0;
    o.alu_op = 4'd15;
    return o;
  endfunction
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      6'h2A: return 4'd7;
      default: return 4'd15;
    endcase
  endfunction
  function automatic logic [3:0] i_alu(input logic [5:0] op);
    if (!IMM) return 4'd15;
    case (op)
      6'h08: return 4'd2;
      6'h0C: return 4'd0;
      6'h0D: return 4'd1;
      6'h0A: return 4'd7;
      default: return 4'd15;
    endcase
  endfunction
  function automatic int cycles(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return r_alu(fn) != 4'd15 ? 4 : 2;
    if (op == 6'h23) return 5;
    if (op == 6'h2B) return 4;
    if (op == 6'h04 || op == 6'h02) return 3;
    return i_alu(op) != 4'd15 ? 4 : 2;
  endfunction
  function automatic obs_t expect_at(input logic [5:0] op, input logic [5:0] fn, input logic z, input int k);
    obs_t o;
    o = idle();
    if (k == 0) begin
      o.pc_en = 1; o.mem_read = 1; o.ir_write = 1; o.alu_src_b = 2'd1; o.alu_op = 4'd2;
    end else if (k == 1) begin
      o.alu_src_b = 2'd3; o.alu_op = 4'd2; o.illegal_op = cycles(op, fn) == 2;
    end else if (op == 6'h00) begin
      if (k == 2) begin o.alu_src_a = 1; o.alu_op = r_alu(fn); end
      else begin o.reg_write = 1; o.reg_dst = 1; end
    end else if (op == 6'h23 || op == 6'h2B) begin
      if (k == 2) begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = 4'd2; end
      else if (k == 4) begin o.reg_write = 1; o.mem_to_reg = 1; end
      else begin o.iord = 1; o.mem_read = op == 6'h23; o.mem_write = op == 6'h2B; end
    end else if (op == 6'h04) begin
      o.alu_src_a = 1; o.alu_op = 4'd6; o.pc_src = 2'd1; o.pc_en = z;
    end else if (op == 6'h02) begin
      o.pc_src = 2'd2; o.pc_en = 1;
    end else if (k == 2) begin
      o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = i_alu(op); o.ext_zero = op == 6'h0C || op == 6'h0D;
    end else begin
      o.reg_write = 1;
    end
    return o;
  endfunction
  // Starts in FETCH (#1 after an edge); ends #1 after the edge that begins the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input string tag, input int abort_at);
    int n;
    bit keep;
    obs_t got, exp;
    n = cycles(op, fn);
    keep = op == 6'h00 || i_alu(op) != 4'd15;
    for (int k = 0; k < n; k++) begin
      bus.opcode = (k == 0 || (k >= 2 && !keep)) ? 6'($urandom) : op;
      bus.funct  = (k == 0 || (k >= 2 && !keep)) ? 6'($urandom) : fn;
      bus.zero   = (k == 2 && op == 6'h04) ? z : 1'($urandom);
      if (k == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.pc_en, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write} !== 5'b0) begin
          bad++;
          $display("FAIL %s reset-cycle enables got=%b want=00000", tag,
                   {bus.pc_en, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        got = observe();
        if (got !== idle()) begin
          bad++;
          $display("FAIL %s hold-after-reset got=%h want=%h", tag, got, idle());
        end
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      total++;
      got = observe();
      exp = expect_at(op, fn, z, k);
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle=%0d op=%h fn=%h got=%h want=%h", tag, k, op, fn, got, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    bus.opcode = 6'h23; bus.funct = 6'h20; bus.zero = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.pc_en, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write} !== 5'b0) begin
      bad++;
      $display("FAIL reset enables got=%b want=00000",
               {bus.pc_en, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    got = observe();
    if (got !== idle()) begin
      bad++;
      $display("FAIL reset hold got=%h want=%h", got, idle());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    run_instr(6'h00, 6'h22, 1'b0, "rtype_sub", -1);
    foreach (fns[i]) run_instr(6'h00, fns[i], 1'b0, "rtype", -1);
  endtask
  task automatic test_branch();
    run_instr(6'h04, 6'h00, 1'b1, "beq_taken", -1);
    run_instr(6'h04, 6'h00, 1'b0, "beq_not_taken", -1);
  endtask
  task automatic test_mem();
    run_instr(6'h23, 6'($urandom), 1'b0, "lw", -1);
    run_instr(6'h2B, 6'($urandom), 1'b0, "sw", -1);
  endtask
  task automatic test_jump();
    run_instr(6'h02, 6'($urandom), 1'b0, "j", -1);
  endtask
  task automatic test_illegal();
    run_instr(6'h3F, 6'($urandom), 1'b0, "illegal_op3f", -1);
    run_instr(6'h00, 6'h01, 1'b0, "illegal_funct01", -1);
  endtask
  task automatic test_imm();
    run_instr(6'h0D, 6'($urandom), 1'b0, "ori", -1);
    run_instr(6'h08, 6'($urandom), 1'b0, "addi", -1);
    run_instr(6'h0C, 6'($urandom), 1'b0, "andi", -1);
    run_instr(6'h0A, 6'($urandom), 1'b0, "slti", -1);
  endtask
  task automatic test_reset_mid();
    run_instr(6'h23, 6'($urandom), 1'b0, "lw_reset_memrd", 3);
    run_instr(6'h00, 6'h20, 1'b0, "after_reset", -1);
  endtask
  task automatic test_back_to_back();
    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] op, fn;
    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      if (i % 37 == 36) run_instr(op, fn, 1'($urandom), "random_reset", $urandom_range(0, 1));
      else run_instr(op, fn, 1'($urandom), "random", -1);
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_mem();
    test_jump();
    test_illegal();
    test_imm();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
